renesas_i2c_target: RTL and testbench

- I2C target (responder) for the open-drain CLKGEN bus: the far end of the axi_iic master path.
- Lets the recovered-clock design run full I2C loopback in simulation (stand-in for the Renesas clock generator), and lets the FPGA expose a register page on a shared I2C bus in hardware.
- Decodes START/STOP and a 7-bit address, a 1-byte register offset with auto-increment, and write and read bursts.
- Reaches an external register store through a simple single-cycle port.

---
 rtl/renesas_i2c_pkg.sv | 20 ++
 rtl/i2c_line_filter.sv | 40 ++++
 rtl/renesas_i2c_target.sv | 208 ++++++++++++++++++++
 tb/tb_renesas_i2c_target.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/renesas_i2c_pkg.sv
// Shared types and constants for the renesas_i2c_target register-page responder.
package renesas_i2c_pkg;

    localparam int         I2C_BITS     = 8;
    localparam logic [6:0] DEF_DEV_ADDR = 7'h5B;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_A,
        OFFS,
        ACK_O,
        WR,
        ACK_W,
        RD,
        MACK,
        IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus a majority-free run-length filter: the output only
// follows the line once FILT_LEN consecutive synchronised samples agree.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic line_i,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0]          sync_q;
    logic [FILT_LEN-1:0] hist_q;

    // Synchronise, collect history and accept a level only after a full stable run.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q <= '1;
            hist_q <= '1;
            line_o <= 1'b1;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            hist_q <= {hist_q[FILT_LEN-2:0], sync_q[1]};
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if ((&hist_q) && !line_o) begin
                line_o <= 1'b1;
                rise_o <= 1'b1;
            end else if (!(|hist_q) && line_o) begin
                line_o <= 1'b0;
                fall_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/renesas_i2c_target.sv
// I2C target exposing a 256-byte register page through a single-cycle store port.
//
// state  | meaning
// IDLE   | bus free or not yet seen a START
// ADDR   | shifting in the address byte
// ACK_A  | driving ACK for our address
// OFFS   | shifting in the register offset
// ACK_O  | driving ACK for the offset
// WR     | shifting in a write data byte
// ACK_W  | driving ACK for a write byte
// RD     | driving a read byte MSB first
// MACK   | sampling the master ACK/NACK after a read byte
// IGNORE | not addressed or read ended; wait for START/STOP
module renesas_i2c_target
    import renesas_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
    parameter int         FILT_LEN = 3,
    parameter int         HOLD_CYC = 8
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_t,
    output logic       reg_wen,
    output logic       reg_ren,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [7:0] nack_cnt
);

    localparam int         HOLD_W   = $clog2(HOLD_CYC + 1);
    localparam logic [2:0] BIT_LAST = 3'(I2C_BITS - 1);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .aclk(aclk), .aresetn(aresetn), .line_i(scl_i),
        .line_o(scl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .aclk(aclk), .aresetn(aresetn), .line_i(sda_i),
        .line_o(sda), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        sreg_q;
    logic [7:0]        offset_q;
    logic              rw_q;
    logic              inc_pend_q;
    logic              rd_cap_q;
    logic              pend_low_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              start_c, stop_c, drive_low_c;
    logic [7:0]        byte_in;

    assign start_c = sda_fall && scl;
    assign stop_c  = sda_rise && scl;
    assign byte_in = {sreg_q[6:0], sda};

    // What SDA should do for the bit phase that opens at the SCL fall just seen.
    always_comb begin
        drive_low_c = 1'b0;
        case (state_q)
            ACK_A, ACK_O, ACK_W: drive_low_c = 1'b1;
            RD:                  drive_low_c = ~sreg_q[7];
            default:             drive_low_c = 1'b0;
        endcase
    end

    // Next-state decode; START/STOP win over any bit activity.
    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = ADDR;
        end else if (stop_c) begin
            state_d = IDLE;
        end else if (scl_rise) begin
            case (state_q)
                ADDR:    if (bit_cnt_q == BIT_LAST)
                             state_d = (byte_in[7:1] == DEV_ADDR) ? ACK_A : IGNORE;
                ACK_A:   state_d = rw_q ? RD : OFFS;
                OFFS:    if (bit_cnt_q == BIT_LAST) state_d = ACK_O;
                ACK_O:   state_d = WR;
                WR:      if (bit_cnt_q == BIT_LAST) state_d = ACK_W;
                ACK_W:   state_d = WR;
                RD:      if (bit_cnt_q == BIT_LAST) state_d = MACK;
                MACK:    state_d = sda ? IGNORE : RD;
                default: state_d = state_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Datapath: shifting, store strobes, offset tracking and held SDA drive.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sda_t      <= 1'b1;
            reg_wen    <= 1'b0;
            reg_ren    <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            busy       <= 1'b0;
            nack_cnt   <= '0;
            bit_cnt_q  <= '0;
            sreg_q     <= '0;
            offset_q   <= '0;
            rw_q       <= 1'b0;
            inc_pend_q <= 1'b0;
            rd_cap_q   <= 1'b0;
            pend_low_q <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            reg_wen  <= 1'b0;
            reg_ren  <= 1'b0;
            rd_cap_q <= reg_ren;
            if (rd_cap_q) sreg_q <= reg_rdata;

            if (hold_cnt_q != '0) begin
                hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                if (hold_cnt_q == HOLD_W'(1)) sda_t <= ~pend_low_q;
            end

            if (start_c || stop_c) begin
                sda_t      <= 1'b1;
                hold_cnt_q <= '0;
                bit_cnt_q  <= '0;
                busy       <= 1'b0;
                inc_pend_q <= 1'b0;
                if (inc_pend_q) offset_q <= offset_q + 8'd1;
            end else begin
                if (scl_fall) begin
                    hold_cnt_q <= HOLD_W'(HOLD_CYC);
                    pend_low_q <= drive_low_c;
                    if (inc_pend_q) begin
                        offset_q   <= offset_q + 8'd1;
                        inc_pend_q <= 1'b0;
                    end
                end
                if (scl_rise) begin
                    case (state_q)
                        ADDR: begin
                            sreg_q    <= byte_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == BIT_LAST && byte_in[7:1] == DEV_ADDR) begin
                                busy <= 1'b1;
                                rw_q <= sda;
                            end
                        end
                        OFFS: begin
                            sreg_q    <= byte_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == BIT_LAST) offset_q <= byte_in;
                        end
                        WR: begin
                            sreg_q    <= byte_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == BIT_LAST) begin
                                reg_wen   <= 1'b1;
                                reg_addr  <= offset_q;
                                reg_wdata <= byte_in;
                            end
                        end
                        ACK_A: begin
                            bit_cnt_q <= '0;
                            if (rw_q) begin
                                reg_ren  <= 1'b1;
                                reg_addr <= offset_q;
                            end
                        end
                        ACK_O: bit_cnt_q <= '0;
                        ACK_W: begin
                            bit_cnt_q  <= '0;
                            inc_pend_q <= 1'b1;
                        end
                        RD: begin
                            sreg_q    <= {sreg_q[6:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                        MACK: begin
                            bit_cnt_q <= '0;
                            if (!sda) begin
                                offset_q <= offset_q + 8'd1;
                                reg_ren  <= 1'b1;
                                reg_addr <= offset_q + 8'd1;
                            end else if (nack_cnt != 8'hFF) begin
                                nack_cnt <= nack_cnt + 8'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_renesas_i2c_target.sv
// Bench: bit-banged I2C master, wired-AND SDA, scoreboard of expected store strobes.
module tb_renesas_i2c_target;

    localparam int HALF = 40;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } strobe_t;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_t;
    logic       reg_wen, reg_ren;
    logic [7:0] reg_addr, reg_wdata, nack_cnt;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       scl_i, sda_i;

    int         n_checks = 0;
    int         n_errors = 0;
    logic       sda_and;
    strobe_t    exp_q[$];

    assign scl_i = scl_m;
    assign sda_i = sda_m & sda_t;

    always #10 aclk = ~aclk;

    renesas_i2c_target dut (
        .aclk(aclk), .aresetn(aresetn), .scl_i(scl_i), .sda_i(sda_i), .sda_t(sda_t),
        .reg_wen(reg_wen), .reg_ren(reg_ren), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .busy(busy), .nack_cnt(nack_cnt)
    );

    function automatic logic [7:0] store_val(input logic [7:0] a);
        if (a == 8'h20)      return 8'h11;
        else if (a == 8'h21) return 8'h22;
        else                 return a ^ 8'h5A;
    endfunction

    // Register store model: data valid the cycle after reg_ren.
    always @(posedge aclk) if (reg_ren) reg_rdata <= store_val(reg_addr);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic wr, input logic [7:0] a, input logic [7:0] d);
        strobe_t e;
        e.wr = wr; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // One aclk cycle; every strobe the DUT emits is matched against the scoreboard here.
    task automatic tick();
        strobe_t e;
        @(negedge aclk);
        sda_and &= sda_t;
        if (reg_wen && reg_ren) check_val("wen_ren_overlap", 32'd1, 32'd0);
        if (reg_wen || reg_ren) begin
            if (exp_q.size() == 0) begin
                check_val("unexp_strobe", {30'd0, reg_wen, reg_ren}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("strobe_wen", 32'(reg_wen), 32'(e.wr));
                check_val("strobe_addr", 32'(reg_addr), 32'(e.addr));
                if (e.wr) check_val("strobe_wdata", 32'(reg_wdata), 32'(e.data));
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_cyc(HALF);
        scl_m = 1'b1; wait_cyc(HALF);
        sda_m = 1'b0; wait_cyc(HALF);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_cyc(HALF);
        scl_m = 1'b1; wait_cyc(HALF);
        sda_m = 1'b1; wait_cyc(HALF);
    endtask

    task automatic clock_bit(input logic b, input logic glitch, output logic r);
        wait_cyc(4);
        sda_m = b;
        wait_cyc(HALF - 4);
        scl_m = 1'b1;
        wait_cyc(HALF / 2);
        r = sda_i;
        if (glitch) begin
            sda_m = ~b; tick(); sda_m = b;
        end
        wait_cyc(HALF / 2);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], glitch, r);
        clock_bit(1'b1, 1'b0, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, 1'b0, r);
            d = {d[6:0], r};
        end
        clock_bit(nack, 1'b0, r);
    endtask

    initial begin
        logic       ack, r;
        logic [7:0] d;
        sda_and = 1'b1;
        #45;
        check_val("rst_sda_t", 32'(sda_t), 32'd1);
        check_val("rst_wen", 32'(reg_wen), 32'd0);
        check_val("rst_ren", 32'(reg_ren), 32'd0);
        check_val("rst_addr", 32'(reg_addr), 32'd0);
        check_val("rst_wdata", 32'(reg_wdata), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_nack", 32'(nack_cnt), 32'd0);
        @(negedge aclk); aresetn = 1'b1;
        wait_cyc(20);

        // Write burst at 0x10.
        i2c_start();
        write_byte(8'hB6, 1'b0, ack); check_val("wr_addr_ack", 32'(ack), 32'd1);
        check_val("wr_busy", 32'(busy), 32'd1);
        write_byte(8'h10, 1'b0, ack); check_val("wr_offs_ack", 32'(ack), 32'd1);
        push_exp(1'b1, 8'h10, 8'hA5);
        write_byte(8'hA5, 1'b0, ack); check_val("wr_d0_ack", 32'(ack), 32'd1);
        push_exp(1'b1, 8'h11, 8'h3C);
        write_byte(8'h3C, 1'b0, ack); check_val("wr_d1_ack", 32'(ack), 32'd1);
        i2c_stop();
        check_val("wr_busy_stop", 32'(busy), 32'd0);
        check_val("wr_sb_empty", 32'(exp_q.size()), 32'd0);

        // Read burst at 0x20 via repeated START.
        i2c_start();
        write_byte(8'hB6, 1'b0, ack); check_val("rd_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h20, 1'b0, ack); check_val("rd_offs_ack", 32'(ack), 32'd1);
        i2c_start();
        push_exp(1'b0, 8'h20, 8'h00);
        write_byte(8'hB7, 1'b0, ack); check_val("rd_raddr_ack", 32'(ack), 32'd1);
        push_exp(1'b0, 8'h21, 8'h00);
        read_byte(1'b0, d); check_val("rd_byte0", 32'(d), 32'h11);
        read_byte(1'b1, d); check_val("rd_byte1", 32'(d), 32'h22);
        check_val("rd_nack_cnt", 32'(nack_cnt), 32'd1);
        wait_cyc(HALF / 2);
        check_val("rd_sda_rel", 32'(sda_t), 32'd1);
        i2c_stop();
        check_val("rd_sb_empty", 32'(exp_q.size()), 32'd0);

        // Wrong address.
        i2c_start();
        sda_and = 1'b1;
        write_byte(8'hA0, 1'b0, ack);
        check_val("bad_addr_ack", 32'(ack), 32'd0);
        check_val("bad_addr_sda", 32'(sda_and), 32'd1);
        check_val("bad_addr_busy", 32'(busy), 32'd0);
        i2c_stop();

        // Glitches on SDA during every data bit's SCL-high phase.
        i2c_start();
        write_byte(8'hB6, 1'b0, ack);
        write_byte(8'h50, 1'b0, ack);
        push_exp(1'b1, 8'h50, 8'h81);
        write_byte(8'h81, 1'b1, ack); check_val("glitch_ack", 32'(ack), 32'd1);
        check_val("glitch_busy", 32'(busy), 32'd1);
        i2c_stop();
        check_val("glitch_sb_empty", 32'(exp_q.size()), 32'd0);

        // Partial byte cut by STOP, then reset in the middle of a read bit.
        i2c_start();
        write_byte(8'hB6, 1'b0, ack);
        write_byte(8'h40, 1'b0, ack);
        clock_bit(1'b1, 1'b0, r); clock_bit(1'b0, 1'b0, r);
        clock_bit(1'b1, 1'b0, r); clock_bit(1'b0, 1'b0, r);
        i2c_stop();
        check_val("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        i2c_start();
        push_exp(1'b0, 8'h40, 8'h00);
        write_byte(8'hB7, 1'b0, ack); check_val("abort_raddr_ack", 32'(ack), 32'd1);
        sda_m = 1'b1;
        wait_cyc(HALF);
        check_val("abort_rd_drive", 32'(sda_t), 32'd0);
        #3 aresetn = 1'b0;
        #1 check_val("abort_rst_sda", 32'(sda_t), 32'd1);
        check_val("abort_rst_nack", 32'(nack_cnt), 32'd0);
        check_val("abort_rst_busy", 32'(busy), 32'd0);
        scl_m = 1'b1;
        wait_cyc(5);
        aresetn = 1'b1;
        wait_cyc(20);
        scl_m = 1'b0;
        sda_and = 1'b1;
        write_byte(8'hB6, 1'b0, ack);
        check_val("nostart_ack", 32'(ack), 32'd0);
        check_val("nostart_sda", 32'(sda_and), 32'd1);
        i2c_stop();

        // Offset wrap 0xFF -> 0x00.
        i2c_start();
        write_byte(8'hB6, 1'b0, ack);
        write_byte(8'hFF, 1'b0, ack);
        push_exp(1'b1, 8'hFF, 8'h12);
        write_byte(8'h12, 1'b0, ack);
        push_exp(1'b1, 8'h00, 8'h34);
        write_byte(8'h34, 1'b0, ack); check_val("wrap_ack", 32'(ack), 32'd1);
        i2c_stop();
        check_val("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
